aes_inv_round_ctrl: RTL

Sequencing controller for the AES inverse-cipher datapath. It walks the shared 128-bit state through the InvShiftRows / InvSubBytes / AddRoundKey / InvMixColumns stages in the correct order for NR rounds. It raises exactly one stage-activate strobe per step, and supplies the round-key index. It stalls on key availability and reports completion to the host. The datapath stages register on the falling clock edge, so each strobe issued in a cycle yields that stage's result before the next rising edge.

---
 rtl/aes_inv_round_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/aes_inv_round_ctrl.sv
// Step sequencer for the AES inverse cipher: one stage strobe per cycle, round-key index, key-valid stalls.
// Latency 4*NR+1 cycles from start to done; stalls one cycle per missing key in INIT_ARK/ARK.
module aes_inv_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_key_valid,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_round,
  output logic       o_sel_input,
  output logic       o_en_ark,
  output logic       o_en_isr,
  output logic       o_en_isb,
  output logic       o_en_imc
);

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_ARK,
    S_ISR,
    S_ISB,
    S_ARK,
    S_IMC,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] round_q;
  logic [3:0] round_nxt;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= S_IDLE;
      round_q <= 4'd0;
    end else begin
      state   <= state_nxt;
      round_q <= round_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    round_nxt   = round_q;
    o_sel_input = 1'b0;
    o_en_ark    = 1'b0;
    o_en_isr    = 1'b0;
    o_en_isb    = 1'b0;
    o_en_imc    = 1'b0;
    o_done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nxt = S_INIT_ARK;
          round_nxt = NR_L;
        end
      end
      S_INIT_ARK: begin
        o_sel_input = 1'b1;
        o_en_ark    = i_key_valid;
        if (i_key_valid) begin
          state_nxt = S_ISR;
          round_nxt = NR_L - 4'd1;
        end
      end
      S_ISR: begin
        o_en_isr  = 1'b1;
        state_nxt = S_ISB;
      end
      S_ISB: begin
        o_en_isb  = 1'b1;
        state_nxt = S_ARK;
      end
      S_ARK: begin
        o_en_ark = i_key_valid;
        // The final round has no InvMixColumns
        if (i_key_valid) state_nxt = (round_q == 4'd0) ? S_DONE : S_IMC;
      end
      S_IMC: begin
        o_en_imc  = 1'b1;
        state_nxt = S_ISR;
        if (round_q != 4'd0) round_nxt = round_q - 4'd1;
      end
      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort only redirects the next state; strobes already issued this cycle stand
    if (i_abort) begin
      state_nxt = S_IDLE;
      round_nxt = 4'd0;
    end
  end

  assign o_busy  = (state != S_IDLE);
  assign o_round = round_q;

endmodule
